fuel_volume_meter: RTL and testbench
====================================

Name: fuel_volume_meter

Overview:
- Parametrised successor to the fixed-step dispensed-volume counter.
- Runs a pumping session with a preset target volume, auto-stop and pause/resume.
- Keeps a saturating lifetime totalizer.
- Sits between the keypad/control FSM (start/stop/clear/target) and the pump relay driver.
- Its volume outputs feed the display and price blocks.

Parameters:
- TICK_CYCLES, 1704545: clk cycles per metering tick. The tick counter counts 0..TICK_CYCLES-1.
- CNT_W, 21: tick counter width. Must satisfy 2^CNT_W >= TICK_CYCLES.
- STEP, 50: volume units added per tick.
- VOL_W, 16: session volume and target width.
- TOT_W, 32: lifetime totalizer width.

Ports:
- clk  in  1  system clock (1 MHz)
- rst  in  1  synchronous active-high reset; clears everything, including the totalizer
- clear  in  1  level; ends the session and zeroes volume (sw0 function)
- start  in  1  one-cycle pulse; begin a new session, or resume a paused one
- stop  in  1  one-cycle pulse; pause pumping
- target  in  VOL_W  session limit, sampled at session start; 0 = unlimited
- flow_en  in  1  relay feedback; metering runs only while this is high (relay_auto function)
- pump_on  out  1  relay request, registered
- volume  out  VOL_W  session volume dispensed
- total  out  TOT_W  lifetime volume, saturating
- done  out  1  one-cycle pulse when the target is reached
- busy  out  1  high in PUMP or PAUSE
- sat  out  1  session volume stuck at 2^VOL_W-1 (unlimited mode only)

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; all counters 0.
  - pump_on=0, volume=0, total=0, done=0, busy=0, sat=0, latched target=0.
- States: IDLE, PUMP, PAUSE, DONE. pump_on=1 only in PUMP.
- Event priority: rst > clear > target-reached > stop > start.
- clear (any state): next state IDLE, volume=0, sat=0, tick counter=0. total is unchanged.
- IDLE --start--> PUMP:
  - volume=0, sat=0, latched target := target.
- DONE --start--> PUMP: same actions as from IDLE (new session).
- PUMP --stop--> PAUSE: volume is held.
- PAUSE --start--> PUMP: resume; volume and latched target are kept.
- start while in PUMP is ignored. stop outside PUMP is ignored.
- Tick counter:
  - Counts only when state=PUMP and flow_en=1.
  - Otherwise it is forced to 0, so a partial interval is discarded.
  - The tick fires in the cycle the counter equals TICK_CYCLES-1; the counter returns to 0 on the next edge.
- On tick, computed in VOL_W+1 bits:
  - sum = volume + STEP.
  - If latched target != 0 and sum >= target: volume := target; state := DONE; done=1 for exactly that next cycle.
  - Else if sum > 2^VOL_W-1: volume := 2^VOL_W-1 and sat := 1. No wrap; the session stays in PUMP.
  - Else volume := sum.
- total += (new volume - old volume), i.e. the clamped amount actually added. It saturates at 2^TOT_W-1 and never wraps.
- Timing:
  - volume, total, done and pump_on all update on the edge following the tick cycle.
  - pump_on falls on the same edge as DONE entry.
- Tick and stop in the same cycle: the tick is accumulated.
  - If the target is reached, the next state is DONE (done pulses); otherwise PAUSE.
- Tick and clear in the same cycle: clear wins; nothing is accumulated into total.
- Target of 0: unlimited. The session ends only by stop or clear.
- Target below STEP: the first tick clamps volume to the target and goes to DONE.
- start in the same cycle as a reached target: DONE is entered; start is ignored that cycle.
- rst mid-session: everything returns to reset values on that edge.

Test Plan (TICK_CYCLES=4, STEP=50 unless stated):
- start with target=200, flow_en=1 held:
  - volume 50/100/150/200 at 4-cycle spacing, first update on the 4th edge after the PUMP entry edge.
  - done high one cycle with volume=200; pump_on falls on that edge; total=200.
- target=120 → volume 50, 100, then 120 (clamped); DONE; total=120.
  - A second start with target=0 → volume restarts at 0; total keeps accumulating from 120.
- PUMP with target=0:
  - flow_en drops for 10 cycles after 2 counts → counter resets, volume holds 0.
  - stop then start → PAUSE, then resume with volume retained and busy=1 throughout.
- VOL_W=8, STEP=100, target=0 → volume 100, 200, then 255 with sat=1; state stays PUMP; total=255.
- stop asserted in the same cycle as the tick that reaches target=150 → volume=150, state DONE, done pulses.
- clear in PUMP at volume=100 → IDLE, volume=0, total=100 kept. rst → total=0 and all outputs 0.

Source files
------------

// File: rtl/fuel_volume_meter.sv
// ============================================================================
// Module   : fuel_volume_meter
// Purpose  : Session volume metering with preset auto-stop, pause/resume and
//            a saturating lifetime totalizer driving the pump relay request.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fuel_volume_meter #(
    parameter int TICK_CYCLES = 1704545,
    parameter int CNT_W       = 21,
    parameter int STEP        = 50,
    parameter int VOL_W       = 16,
    parameter int TOT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic [VOL_W-1:0] target,
    input  logic             flow_en,
    output logic             pump_on,
    output logic [VOL_W-1:0] volume,
    output logic [TOT_W-1:0] total,
    output logic             done,
    output logic             busy,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUMP  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [VOL_W:0]   C_STEP      = (VOL_W + 1)'(STEP);
    localparam logic [VOL_W:0]   C_VOL_MAX   = {1'b0, {VOL_W{1'b1}}};
    localparam logic [TOT_W:0]   C_TOT_MAX   = {1'b0, {TOT_W{1'b1}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VOL_W-1:0]   vol_q, vol_d;
    logic [VOL_W-1:0]   tgt_q, tgt_d;
    logic [TOT_W-1:0]   tot_q, tot_d;
    logic               done_q, done_d;
    logic               sat_q, sat_d;
    logic               pump_q;

    logic               w_metering;
    logic               w_tick;
    logic               w_reached;
    logic [VOL_W:0]     w_sum;
    logic [TOT_W:0]     w_tot_sum;

    assign w_metering = (state_q == PUMP) && flow_en;
    assign w_tick     = w_metering && (cnt_q == C_TICK_LAST);
    assign w_sum      = {1'b0, vol_q} + C_STEP;
    assign w_reached  = w_tick && (tgt_q != '0) && (w_sum >= {1'b0, tgt_q});

    always_comb begin
        state_d   = state_q;
        vol_d     = vol_q;
        tgt_d     = tgt_q;
        tot_d     = tot_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        w_tot_sum = '0;
        cnt_d     = '0;

        // A partial interval is discarded whenever metering is interrupted.
        if (w_metering && !w_tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (clear) begin
            state_d = IDLE;
            vol_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            if (w_tick) begin
                if (w_reached) begin
                    vol_d   = tgt_q;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (w_sum > C_VOL_MAX) begin
                    vol_d = C_VOL_MAX[VOL_W-1:0];
                    sat_d = 1'b1;
                end else begin
                    vol_d = w_sum[VOL_W-1:0];
                end
                // Only the clamped increment reaches the totalizer.
                w_tot_sum = {1'b0, tot_q} + (TOT_W + 1)'(vol_d - vol_q);
                tot_d     = (w_tot_sum > C_TOT_MAX) ? C_TOT_MAX[TOT_W-1:0]
                                                    : w_tot_sum[TOT_W-1:0];
            end

            if (!w_reached) begin
                if (stop && (state_q == PUMP)) begin
                    state_d = PAUSE;
                end else if (start) begin
                    case (state_q)
                        IDLE, DONE: begin
                            state_d = PUMP;
                            vol_d   = '0;
                            sat_d   = 1'b0;
                            tgt_d   = target;
                            cnt_d   = '0;
                        end
                        PAUSE:   state_d = PUMP;
                        default: state_d = state_q;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vol_q   <= '0;
            tgt_q   <= '0;
            tot_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            pump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vol_q   <= vol_d;
            tgt_q   <= tgt_d;
            tot_q   <= tot_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            pump_q  <= (state_d == PUMP);
        end
    end

    assign pump_on = pump_q;
    assign volume  = vol_q;
    assign total   = tot_q;
    assign done    = done_q;
    assign sat     = sat_q;
    assign busy    = (state_q == PUMP) || (state_q == PAUSE);

endmodule

`default_nettype wire

// File: tb/tb_fuel_volume_meter.sv
// ============================================================================
// Module   : tb_fuel_volume_meter
// Purpose  : Directed self-checking bench for fuel_volume_meter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fuel_volume_meter;

    logic        clk = 1'b0;
    logic        rst, clear, start, stop, flow_en;
    logic [15:0] target;
    logic        pump_on, done, busy, sat;
    logic [15:0] volume;
    logic [31:0] total;

    logic        start_b;
    logic [7:0]  target_b;
    logic        pump_on_b, done_b, busy_b, sat_b;
    logic [7:0]  volume_b;
    logic [31:0] total_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fuel_volume_meter #(
        .TICK_CYCLES(4), .CNT_W(3), .STEP(50), .VOL_W(16), .TOT_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
        .target(target), .flow_en(flow_en), .pump_on(pump_on),
        .volume(volume), .total(total), .done(done), .busy(busy), .sat(sat)
    );

    fuel_volume_meter #(
        .TICK_CYCLES(4), .CNT_W(3), .STEP(100), .VOL_W(8), .TOT_W(32)
    ) u_dut_b (
        .clk(clk), .rst(rst), .clear(clear), .start(start_b), .stop(1'b0),
        .target(target_b), .flow_en(flow_en), .pump_on(pump_on_b),
        .volume(volume_b), .total(total_b), .done(done_b), .busy(busy_b),
        .sat(sat_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0; flow_en = 1'b1;
        target = '0; start_b = 1'b0; target_b = '0;
        step(2);
        rst = 1'b0;
        check("rst_volume", volume, 0);
        check("rst_total", total, 0);
        check("rst_pump", pump_on, 0);
        check("rst_busy", busy, 0);
        check("rst_done_sat", {done, sat}, 0);

        // Session to 200
        target = 16'd200; start = 1'b1; step(1); start = 1'b0;
        check("s1_entry_pump", pump_on, 1);
        check("s1_entry_busy", busy, 1);
        step(3); check("s1_pre_tick", volume, 0);
        step(1); check("s1_v50", volume, 50);
        step(4); check("s1_v100", volume, 100);
        step(4); check("s1_v150", volume, 150);
        step(3); check("s1_hold150", volume, 150);
        step(1);
        check("s1_v200", volume, 200);
        check("s1_done", done, 1);
        check("s1_pump_off", pump_on, 0);
        check("s1_total", total, 200);
        step(1);
        check("s1_done_pulse", done, 0);
        check("s1_idle_busy", busy, 0);

        // Clamped target 120, started from DONE
        target = 16'd120; start = 1'b1; step(1); start = 1'b0;
        check("s2_restart_vol", volume, 0);
        step(4); check("s2_v50", volume, 50);
        step(4); check("s2_v100", volume, 100);
        step(4);
        check("s2_v120", volume, 120);
        check("s2_done", done, 1);
        check("s2_total", total, 320);

        // Unlimited session, flow dropout discards partial interval
        target = 16'd0; start = 1'b1; step(1); start = 1'b0;
        check("s3_restart_vol", volume, 0);
        check("s3_total_kept", total, 320);
        step(2);
        flow_en = 1'b0; step(10);
        check("s3_noflow_vol", volume, 0);
        check("s3_noflow_pump", pump_on, 1);
        flow_en = 1'b1; step(3);
        check("s3_cnt_reset", volume, 0);
        step(1);
        check("s3_v50", volume, 50);
        check("s3_total", total, 370);

        // Pause and resume
        stop = 1'b1; step(1); stop = 1'b0;
        check("s4_pause_pump", pump_on, 0);
        check("s4_pause_busy", busy, 1);
        step(6);
        check("s4_pause_hold", volume, 50);
        start = 1'b1; step(1); start = 1'b0;
        check("s4_resume_pump", pump_on, 1);
        check("s4_resume_vol", volume, 50);
        step(4);
        check("s4_v100", volume, 100);
        check("s4_total", total, 420);

        // Clear in PUMP
        clear = 1'b1; step(1); clear = 1'b0;
        check("s5_clear_vol", volume, 0);
        check("s5_clear_busy", busy, 0);
        check("s5_clear_total", total, 420);

        // Stop coinciding with the tick that reaches the target
        target = 16'd150; start = 1'b1; step(1); start = 1'b0;
        step(8); check("s6_v100", volume, 100);
        step(3); stop = 1'b1; step(1); stop = 1'b0;
        check("s6_v150", volume, 150);
        check("s6_done", done, 1);
        check("s6_not_busy", busy, 0);
        check("s6_total", total, 570);

        // Clear coinciding with a tick
        target = 16'd0; start = 1'b1; step(1); start = 1'b0;
        step(3); clear = 1'b1; step(1); clear = 1'b0;
        check("s7_clear_tick_vol", volume, 0);
        check("s7_clear_tick_total", total, 570);

        // Target below STEP
        target = 16'd30; start = 1'b1; step(1); start = 1'b0;
        step(4);
        check("s8_v30", volume, 30);
        check("s8_done", done, 1);
        check("s8_total", total, 600);

        // Reset mid-session
        target = 16'd0; start = 1'b1; step(1); start = 1'b0;
        step(4); check("s9_total", total, 650);
        rst = 1'b1; step(1); rst = 1'b0;
        check("s9_rst_total", total, 0);
        check("s9_rst_volume", volume, 0);
        check("s9_rst_pump_busy", {pump_on, busy}, 0);

        // Narrow instance: saturation in unlimited mode
        start_b = 1'b1; step(1); start_b = 1'b0;
        step(4); check("b_v100", volume_b, 100);
        step(4); check("b_v200", volume_b, 200);
        check("b_sat_low", sat_b, 0);
        step(4);
        check("b_v255", volume_b, 255);
        check("b_sat", sat_b, 1);
        check("b_still_pump", {pump_on_b, busy_b, done_b}, 3'b110);
        check("b_total", total_b, 255);
        step(4);
        check("b_hold255", volume_b, 255);
        check("b_total_hold", total_b, 255);
        clear = 1'b1; step(1); clear = 1'b0;
        check("b_clear_sat", sat_b, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000ns");
        $fatal(1);
    end

endmodule

`default_nettype wire
